// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes
// and the FSM state encoding used by mem_lsu.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response bus between the EX/MEM pipeline register (master) and
// the load/store unit (slave). The stall line to the hazard unit rides along.
interface mem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        stall;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, stall
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata, stall
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the load/store unit (big-endian byte order):
// load lane extract with sign/zero extension, store lane merge into a word
// read from dm, and the alignment / reserved-size check.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data,
    output logic        misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the read word (byte 0 is the MSB lane).
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane)
            2'd0:    byte_s = rword[31:24];
            2'd1:    byte_s = rword[23:16];
            2'd2:    byte_s = rword[15:8];
            2'd3:    byte_s = rword[7:0];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rword[15:0];
        end else begin
            half_s = rword[31:16];
        end
    end

    // Extend the selected lane into the 32-bit load result.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = {{24{sgn & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sgn & half_s[15]}}, half_s};
            SZ_WORD: load_data = rword;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane of the read word with the store data.
    always_comb begin
        merge_data = rword;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merge_data[31:24] = wdata[7:0];
                    2'd1:    merge_data[23:16] = wdata[7:0];
                    2'd2:    merge_data[15:8]  = wdata[7:0];
                    2'd3:    merge_data[7:0]   = wdata[7:0];
                    default: merge_data = rword;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merge_data[15:0] = wdata[15:0];
                end else begin
                    merge_data[31:16] = wdata[15:0];
                end
            end
            SZ_WORD: merge_data = wdata;
            default: merge_data = rword;
        endcase
    end

    // Halves need an even address, words a multiple of four; size 11 is never legal.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane;
            SZ_RSVD: misaligned = 1'b1;
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw
// requests into word-wide dm read/write cycles; sub-word stores are done as
// read-modify-write. The pipeline is stalled while an access is in flight.
// Optional feature macro: LSU_BOUNDS_CHECK_EN -- when defined, any address
// with nonzero bits above the dm range is rejected with resp_err; otherwise
// those bits are ignored and the address wraps.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_lsu_if.slave          bus,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    lsu_state_e        state_r;
    lsu_state_e        state_n;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        lane_r;
    logic [1:0]        size_r;
    logic              sgn_r;
    logic              wr_r;
    logic              err_r;
    logic [31:0]       data_r;
    logic [31:0]       rdata_r;

    logic              accept_s;
    logic              bad_s;
    logic              oob_s;
    logic              misaligned_s;
    logic [1:0]        chk_size_s;
    logic [1:0]        chk_lane_s;
    logic [31:0]       load_s;
    logic [31:0]       merge_s;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob_s = |bus.req_addr[31:ADDR_W+2];
`else
    logic unused_hi_addr_s;
    assign unused_hi_addr_s = ^bus.req_addr[31:ADDR_W+2];
    assign oob_s = 1'b0;
`endif

    // In IDLE the alignment check looks at the incoming request; later the lane
    // logic works on the latched request.
    assign chk_size_s = (state_r == ST_IDLE) ? bus.req_size      : size_r;
    assign chk_lane_s = (state_r == ST_IDLE) ? bus.req_addr[1:0] : lane_r;

    mem_lsu_align u_align (
        .size       (chk_size_s),
        .sgn        (sgn_r),
        .lane       (chk_lane_s),
        .rword      (dm_rdata),
        .wdata      (data_r),
        .load_data  (load_s),
        .merge_data (merge_s),
        .misaligned (misaligned_s)
    );

    assign bad_s = misaligned_s | oob_s;

    // Next-state decode: choose the access path at accept, then walk the fixed sequence.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (bad_s) begin
                        state_n = ST_DONE;
                    end else if (bus.req_wr && (bus.req_size == SZ_WORD)) begin
                        state_n = ST_WR;
                    end else begin
                        state_n = ST_RD;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RD:   state_n = ST_WAIT;
            ST_WAIT: begin
                if (wr_r) begin
                    state_n = ST_WR;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_WR:   state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Request latch at accept, and capture of dm read data in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            lane_r  <= 2'b00;
            size_r  <= 2'b00;
            sgn_r   <= 1'b0;
            wr_r    <= 1'b0;
            err_r   <= 1'b0;
            data_r  <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                addr_r <= bus.req_addr[ADDR_W+1:2];
                lane_r <= bus.req_addr[1:0];
                size_r <= bus.req_size;
                sgn_r  <= bus.req_signed;
                wr_r   <= bus.req_wr;
                err_r  <= bad_s;
                data_r <= bus.req_wdata;
            end
            if (state_r == ST_WAIT) begin
                if (wr_r) begin
                    data_r <= merge_s;
                end else begin
                    rdata_r <= load_s;
                end
            end
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.stall      = (state_r != ST_IDLE);
    assign bus.resp_valid = (state_r == ST_DONE);
    assign bus.resp_err   = (state_r == ST_DONE) & err_r;
    assign bus.resp_rdata = rdata_r;

    assign dm_rd    = (state_r == ST_RD);
    assign dm_wr    = (state_r == ST_WR);
    assign dm_addr  = addr_r;
    assign dm_wdata = data_r;

endmodule
